avalon_nn_host: RTL

- Avalon-MM initiator that drives the neural-network accelerator's Avalon-MM slave port through one full inference.
- Sequence: clear, stream pixel words (and optionally weight words) from a local source, set start, poll status until done, drop start, read back all result registers.
- Sits between a local data source (frame buffer / DMA FIFO) and the accelerator's bus port.
- One transaction in flight at a time; single-beat transfers only.

---
 rtl/nn_bus_pkg.sv | 57 +++++
 rtl/avalon_single_xfer.sv | 109 ++++++++++
 rtl/avalon_nn_host.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/nn_bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : nn_bus_pkg                                                |
// | Purpose  : Address map, register bit positions and state encodings   |
// |            shared by the NN accelerator bus host and its transfer    |
// |            engine.                                                   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package nn_bus_pkg;

  // Accelerator address map (word addresses on a 13-bit bus)
  localparam logic [12:0] c_pix_base   = 13'd0;
  localparam int          c_pix_words  = 98;
  localparam logic [12:0] c_wgt_base   = 13'd196;
  localparam int          c_wgt_words  = 3920;
  localparam logic [12:0] c_res_base   = 13'd4116;
  localparam int          c_n_results  = 10;
  localparam logic [12:0] c_ctrl_addr  = 13'd4126;
  localparam logic [12:0] c_stat_addr  = 13'd4127;
  localparam logic [15:0] c_poll_limit = 16'd65535;

  // Control register bits
  localparam int c_ctrl_clear = 0;
  localparam int c_ctrl_start = 3;

  // Status register bits
  localparam int c_stat_done = 0;
  localparam int c_stat_ovf  = 1;

  // Control words written during a run
  localparam logic [31:0] c_ctrl_clr_word   = 32'h1 << c_ctrl_clear;
  localparam logic [31:0] c_ctrl_start_word = 32'h1 << c_ctrl_start;
  localparam logic [31:0] c_ctrl_idle_word  = 32'h0;

  // Host sequencing states
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_CLR1  = 4'd1,
    ST_CLR0  = 4'd2,
    ST_PIX   = 4'd3,
    ST_WGT   = 4'd4,
    ST_START = 4'd5,
    ST_POLL  = 4'd6,
    ST_STOP  = 4'd7,
    ST_RES   = 4'd8,
    ST_FIN   = 4'd9
  } host_state_t;

  // Single-transfer engine states
  typedef enum logic [1:0] {
    XS_IDLE = 2'd0,
    XS_HOLD = 2'd1,
    XS_WAIT = 2'd2
  } xfer_state_t;

endpackage
`default_nettype wire

// File: rtl/avalon_single_xfer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : avalon_single_xfer                                        |
// | Purpose  : One Avalon-MM single-beat read or write handshake.        |
// |            A request is presented on the bus in the cycle it is      |
// |            raised; if the slave stalls, the command is captured and  |
// |            held unchanged until waitrequest drops. Reads then wait   |
// |            for readdatavalid before the next request is taken.       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module avalon_single_xfer
  import nn_bus_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  // request side
  input  logic        req,
  input  logic        rnw,
  input  logic [12:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        rvalid,
  // Avalon side
  output logic [12:0] address,
  output logic        write,
  output logic        read,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  input  logic        readdatavalid
);

  xfer_state_t r_state;
  xfer_state_t w_next_state;
  logic [12:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_rnw;

  // Transfer state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= XS_IDLE;
    else        r_state <= w_next_state;
  end

  // Capture the command as it is first presented so a stall cannot disturb it
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_addr  <= 13'd0;
      r_wdata <= 32'd0;
      r_rnw   <= 1'b0;
    end else if (r_state == XS_IDLE && req) begin
      r_addr  <= addr;
      r_wdata <= wdata;
      r_rnw   <= rnw;
    end
  end

  // Bus drive and handshake decode
  always_comb begin
    w_next_state = r_state;
    address      = 13'd0;
    write        = 1'b0;
    read         = 1'b0;
    writedata    = 32'd0;
    ack          = 1'b0;
    rvalid       = 1'b0;
    rdata        = 32'd0;
    case (r_state)
      XS_IDLE: begin
        // address follows the requester even with no request so that it
        // stays put across idle source cycles
        address = addr;
        if (req) begin
          write     = ~rnw;
          read      = rnw;
          writedata = rnw ? 32'd0 : wdata;
          if (!waitrequest) begin
            ack          = 1'b1;
            w_next_state = rnw ? XS_WAIT : XS_IDLE;
          end else begin
            w_next_state = XS_HOLD;
          end
        end
      end
      XS_HOLD: begin
        address   = r_addr;
        write     = ~r_rnw;
        read      = r_rnw;
        writedata = r_rnw ? 32'd0 : r_wdata;
        if (!waitrequest) begin
          ack          = 1'b1;
          w_next_state = r_rnw ? XS_WAIT : XS_IDLE;
        end
      end
      XS_WAIT: begin
        address = r_addr;
        if (readdatavalid) begin
          rvalid       = 1'b1;
          rdata        = readdata;
          w_next_state = XS_IDLE;
        end
      end
      default: w_next_state = XS_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/avalon_nn_host.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : avalon_nn_host                                            |
// | Purpose  : Avalon-MM initiator that walks the NN accelerator through |
// |            one inference: clear, load pixels (and optionally         |
// |            weights) from a local source, start, poll for done, stop  |
// |            and read back every result register.                      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module avalon_nn_host
  import nn_bus_pkg::*;
#(
  parameter logic [12:0] PIX_BASE   = c_pix_base,
  parameter int          PIX_WORDS  = c_pix_words,
  parameter logic [12:0] WGT_BASE   = c_wgt_base,
  parameter int          WGT_WORDS  = c_wgt_words,
  parameter logic [12:0] RES_BASE   = c_res_base,
  parameter int          N_RESULTS  = c_n_results,
  parameter logic [12:0] CTRL_ADDR  = c_ctrl_addr,
  parameter logic [12:0] STAT_ADDR  = c_stat_addr,
  parameter logic [15:0] POLL_LIMIT = c_poll_limit
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        go,
  input  logic        load_weights,
  input  logic        src_valid,
  input  logic [31:0] src_data,
  output logic        src_ready,
  output logic [12:0] address,
  output logic        write,
  output logic        read,
  output logic [31:0] writedata,
  output logic        beginbursttransfer,
  output logic [9:0]  burstcount,
  input  logic [31:0] readdata,
  input  logic        readdatavalid,
  input  logic        waitrequest,
  input  logic [1:0]  response,
  output logic        busy,
  output logic        done,
  output logic        overflow_flag,
  output logic        error,
  output logic        result_valid,
  output logic [3:0]  result_idx,
  output logic [16:0] result_data
);

  localparam logic [11:0] c_pix_last = 12'(PIX_WORDS - 1);
  localparam logic [11:0] c_wgt_last = 12'(WGT_WORDS - 1);
  localparam logic [11:0] c_res_last = 12'(N_RESULTS - 1);

  host_state_t r_state;
  host_state_t w_next_state;

  logic [11:0] r_word_cnt;
  logic [15:0] r_poll_cnt;
  logic        r_load_wgt;
  logic        r_error;
  logic        r_ovf;

  logic        w_req;
  logic        w_rnw;
  logic [12:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_ack;
  logic [31:0] w_rdata;
  logic        w_rvalid;

  logic [15:0] w_poll_inc;
  logic        w_word_last;
  logic        w_data_phase;
  logic        w_unused;

  assign w_poll_inc   = r_poll_cnt + 16'd1;
  assign w_data_phase = (r_state == ST_PIX) || (r_state == ST_WGT);
  assign w_word_last  = (r_state == ST_PIX) ? (r_word_cnt == c_pix_last) :
                        (r_state == ST_WGT) ? (r_word_cnt == c_wgt_last) :
                                              (r_word_cnt == c_res_last);

  avalon_single_xfer u_xfer (
    .clk           (clk),
    .n_rst         (n_rst),
    .req           (w_req),
    .rnw           (w_rnw),
    .addr          (w_addr),
    .wdata         (w_wdata),
    .ack           (w_ack),
    .rdata         (w_rdata),
    .rvalid        (w_rvalid),
    .address       (address),
    .write         (write),
    .read          (read),
    .writedata     (writedata),
    .waitrequest   (waitrequest),
    .readdata      (readdata),
    .readdatavalid (readdatavalid)
  );

  // Host state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next state and the request presented to the transfer engine
  always_comb begin
    w_next_state = r_state;
    w_req        = 1'b0;
    w_rnw        = 1'b0;
    w_addr       = 13'd0;
    w_wdata      = 32'd0;
    case (r_state)
      ST_IDLE: begin
        if (go) w_next_state = ST_CLR1;
      end
      ST_CLR1: begin
        w_req   = 1'b1;
        w_addr  = CTRL_ADDR;
        w_wdata = c_ctrl_clr_word;
        if (w_ack) w_next_state = ST_CLR0;
      end
      ST_CLR0: begin
        w_req   = 1'b1;
        w_addr  = CTRL_ADDR;
        w_wdata = c_ctrl_idle_word;
        if (w_ack) w_next_state = ST_PIX;
      end
      ST_PIX: begin
        // two pixels per word, so word k lands at base + 2k
        w_req   = src_valid;
        w_addr  = PIX_BASE + {r_word_cnt, 1'b0};
        w_wdata = src_data;
        if (w_ack && w_word_last) w_next_state = r_load_wgt ? ST_WGT : ST_START;
      end
      ST_WGT: begin
        w_req   = src_valid;
        w_addr  = WGT_BASE + {1'b0, r_word_cnt};
        w_wdata = src_data;
        if (w_ack && w_word_last) w_next_state = ST_START;
      end
      ST_START: begin
        w_req   = 1'b1;
        w_addr  = CTRL_ADDR;
        w_wdata = c_ctrl_start_word;
        if (w_ack) w_next_state = ST_POLL;
      end
      ST_POLL: begin
        w_req  = 1'b1;
        w_rnw  = 1'b1;
        w_addr = STAT_ADDR;
        if (w_rvalid) begin
          if (w_rdata[c_stat_done])         w_next_state = ST_STOP;
          else if (w_poll_inc == POLL_LIMIT) w_next_state = ST_STOP;
        end
      end
      ST_STOP: begin
        w_req   = 1'b1;
        w_addr  = CTRL_ADDR;
        w_wdata = c_ctrl_idle_word;
        if (w_ack) w_next_state = r_error ? ST_FIN : ST_RES;
      end
      ST_RES: begin
        w_req  = 1'b1;
        w_rnw  = 1'b1;
        w_addr = RES_BASE + {1'b0, r_word_cnt};
        if (w_rvalid && w_word_last) w_next_state = ST_FIN;
      end
      ST_FIN: begin
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Word/poll counters and the sticky run flags
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_word_cnt <= 12'd0;
      r_poll_cnt <= 16'd0;
      r_load_wgt <= 1'b0;
      r_error    <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (go) begin
            r_word_cnt <= 12'd0;
            r_poll_cnt <= 16'd0;
            r_load_wgt <= load_weights;
            r_error    <= 1'b0;
            r_ovf      <= 1'b0;
          end
        end
        ST_PIX, ST_WGT: begin
          if (w_ack) r_word_cnt <= w_word_last ? 12'd0 : r_word_cnt + 12'd1;
        end
        ST_POLL: begin
          if (w_rvalid) begin
            if (w_rdata[c_stat_done]) begin
              r_ovf <= w_rdata[c_stat_ovf];
            end else begin
              r_poll_cnt <= w_poll_inc;
              if (w_poll_inc == POLL_LIMIT) r_error <= 1'b1;
            end
          end
        end
        ST_RES: begin
          if (w_rvalid) r_word_cnt <= w_word_last ? 12'd0 : r_word_cnt + 12'd1;
        end
        default: ;
      endcase
      // a bad read response is recorded but the sequence carries on
      if (w_rvalid && (response != 2'b00)) r_error <= 1'b1;
    end
  end

  assign src_ready          = w_data_phase & write & ~waitrequest;
  assign busy               = (r_state != ST_IDLE) && (r_state != ST_FIN);
  assign done               = (r_state == ST_FIN);
  assign overflow_flag      = r_ovf;
  assign error              = r_error;
  assign result_valid       = (r_state == ST_RES) && w_rvalid;
  assign result_idx         = r_word_cnt[3:0];
  assign result_data        = w_rdata[16:0];
  assign beginbursttransfer = 1'b0;
  assign burstcount         = 10'd1;

  // only the low result bits and the status flags are consumed
  assign w_unused = &{1'b0, w_rdata[31:17]};

endmodule
`default_nettype wire
